mc_host_regs: RTL and testbench

//  Host-side register front end for the Monte Carlo engine. Decodes a 16-bit

---
 rtl/mc_host_regs.sv | 196 +++++++++++++++++++
 tb/tb_mc_host_regs.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_host_regs.sv
// Host register front end for the Monte Carlo engine: synchronized 16-bit bus,
// engine parameter/control registers, run-window FSM and coherent result snapshots.
module mc_host_regs #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DRAIN_CYC   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_cs,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [3:0]  bus_addr,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic [15:0] KerT,
  output logic [15:0] Se05sigmaT,
  output logic [15:0] sigmaSqrtT,
  output logic        Status,
  output logic        Mode,
  input  logic [63:0] sum_in,
  input  logic [63:0] sum_square_in,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 32;
  localparam int unsigned RW  = 64;
  localparam int unsigned DRW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DRW-1:0]  dcnt_q, dcnt_d;

  logic [SYNC_STAGES-1:0] cs_sync, wr_sync, rd_sync;
  logic            wr_lvl, rd_lvl, wr_lvl_q, rd_lvl_q;
  logic            wr_ev, rd_ev;

  logic [DW-1:0]   runlen_lo, runlen_hi;
  logic [CW-1:0]   run_len;
  logic [RW-1:0]   snap_sum, snap_sq;

  logic            ctrl_wr, start_req, abort_req, clr_req, start_ok;

  // Strobe synchronizers and rising-edge detect of the qualified strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync  <= '0;
      wr_sync  <= '0;
      rd_sync  <= '0;
      wr_lvl_q <= 1'b0;
      rd_lvl_q <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus_cs};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], bus_wr};
      rd_sync  <= {rd_sync[SYNC_STAGES-2:0], bus_rd};
      wr_lvl_q <= wr_lvl;
      rd_lvl_q <= rd_lvl;
    end
  end

  assign wr_lvl = cs_sync[SYNC_STAGES-1] & wr_sync[SYNC_STAGES-1];
  assign rd_lvl = cs_sync[SYNC_STAGES-1] & rd_sync[SYNC_STAGES-1];
  assign wr_ev  = wr_lvl & ~wr_lvl_q;
  assign rd_ev  = rd_lvl & ~rd_lvl_q;

  assign ctrl_wr   = wr_ev && (bus_addr == 4'h0);
  assign start_req = ctrl_wr & bus_wdata[0];
  assign abort_req = ctrl_wr & bus_wdata[1];
  assign clr_req   = ctrl_wr & bus_wdata[3];
  assign run_len   = {runlen_hi, runlen_lo};
  // ABORT in the same write beats START; a zero-length run is never started
  assign start_ok  = start_req & ~abort_req & (run_len != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      Status  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      Status  <= (state_d == ST_RUN);
      busy    <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done    <= (state_d == ST_DONE);
    end
  end

  // Run window: cnt counts down from run_len to 1, so it can never wrap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          cnt_d   = run_len;
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = ST_DRAIN;
          dcnt_d  = DRW'(DRAIN_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRAIN: begin
        if (abort_req) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          dcnt_d = dcnt_q - DRW'(1);
        end
      end
      ST_DONE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          cnt_d   = run_len;
        end else if (clr_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Host writes; parameter and length registers are frozen while busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Mode       <= 1'b0;
      KerT       <= '0;
      Se05sigmaT <= '0;
      sigmaSqrtT <= '0;
      runlen_lo  <= '0;
      runlen_hi  <= '0;
    end else if (wr_ev) begin
      case (bus_addr)
        4'h0: Mode <= bus_wdata[2];
        4'h1: if (!busy) KerT       <= bus_wdata;
        4'h2: if (!busy) Se05sigmaT <= bus_wdata;
        4'h3: if (!busy) sigmaSqrtT <= bus_wdata;
        4'h4: if (!busy) runlen_lo  <= bus_wdata;
        4'h5: if (!busy) runlen_hi  <= bus_wdata;
        default: ;
      endcase
    end
  end

  // Host reads; only address 0x8 samples the live engine results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_rdata <= '0;
      snap_sum  <= '0;
      snap_sq   <= '0;
    end else if (rd_ev) begin
      case (bus_addr)
        4'h0: bus_rdata <= {13'b0, Mode, done, busy};
        4'h1: bus_rdata <= KerT;
        4'h2: bus_rdata <= Se05sigmaT;
        4'h3: bus_rdata <= sigmaSqrtT;
        4'h4: bus_rdata <= runlen_lo;
        4'h5: bus_rdata <= runlen_hi;
        4'h8: begin
          snap_sum  <= sum_in;
          snap_sq   <= sum_square_in;
          bus_rdata <= sum_in[15:0];
        end
        4'h9: bus_rdata <= snap_sum[31:16];
        4'hA: bus_rdata <= snap_sum[47:32];
        4'hB: bus_rdata <= snap_sum[63:48];
        4'hC: bus_rdata <= snap_sq[15:0];
        4'hD: bus_rdata <= snap_sq[31:16];
        4'hE: bus_rdata <= snap_sq[47:32];
        4'hF: bus_rdata <= snap_sq[63:48];
        default: bus_rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_host_regs.sv
// Directed bench for mc_host_regs: register access, run window, abort,
// snapshots and asynchronous reset.
module tb_mc_host_regs;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DRAIN_CYC   = 8;
  localparam int unsigned HOLD        = SYNC_STAGES + 4;

  logic        clk;
  logic        reset;
  logic        bus_cs, bus_wr, bus_rd;
  logic [3:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic [15:0] KerT, Se05sigmaT, sigmaSqrtT;
  logic        Status, Mode, busy, done;
  logic [63:0] sum_in, sum_square_in;

  int n_checks = 0;
  int n_errors = 0;
  int status_total = 0;
  int busy_total = 0;

  mc_host_regs #(
    .SYNC_STAGES(SYNC_STAGES),
    .DRAIN_CYC  (DRAIN_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_cs       (bus_cs),
    .bus_wr       (bus_wr),
    .bus_rd       (bus_rd),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .KerT         (KerT),
    .Se05sigmaT   (Se05sigmaT),
    .sigmaSqrtT   (sigmaSqrtT),
    .Status       (Status),
    .Mode         (Mode),
    .sum_in       (sum_in),
    .sum_square_in(sum_square_in),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counters for the run-window length checks
  always @(negedge clk) begin
    if (Status) status_total++;
    if (busy)   busy_total++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus_addr  = a;
    bus_wdata = d;
    bus_cs    = 1'b1;
    bus_wr    = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1;
    bus_wr = 1'b0;
    bus_cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    bus_addr = a;
    bus_cs   = 1'b1;
    bus_rd   = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1;
    d      = bus_rdata;
    bus_rd = 1'b0;
    bus_cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] rd;
    int s0, b0;

    reset = 1'b1;
    bus_cs = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
    bus_addr = 4'h0; bus_wdata = 16'h0;
    sum_in = 64'h0; sum_square_in = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata",  64'(bus_rdata), 64'h0);
    check("rst_kert",   64'(KerT), 64'h0);
    check("rst_status", 64'(Status), 64'h0);
    check("rst_busy",   64'(busy), 64'h0);
    check("rst_done",   64'(done), 64'h0);
    check("rst_mode",   64'(Mode), 64'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Parameter registers
    bus_write(4'h1, 16'h8001);
    bus_write(4'h2, 16'h1234);
    bus_write(4'h3, 16'h7FFF);
    check("kert_port", 64'(KerT), 64'h8001);
    bus_read(4'h1, rd); check("rd_kert", 64'(rd), 64'h8001);
    bus_read(4'h2, rd); check("rd_se05", 64'(rd), 64'h1234);
    bus_read(4'h3, rd); check("rd_sigsq", 64'(rd), 64'h7FFF);
    bus_read(4'h6, rd); check("rd_unmapped", 64'(rd), 64'h0);

    // Five-cycle run: Status 5 cycles, busy 5+8
    bus_write(4'h4, 16'd5);
    bus_write(4'h5, 16'd0);
    s0 = status_total; b0 = busy_total;
    bus_write(4'h0, 16'h0001);
    for (int i = 0; i < 100 && !done; i++) @(posedge clk);
    #1;
    check("run5_done", 64'(done), 64'h1);
    check("run5_status_cyc", 64'(status_total - s0), 64'd5);
    check("run5_busy_cyc", 64'(busy_total - b0), 64'd13);
    bus_read(4'h0, rd); check("run5_ctrl", 64'(rd), 64'h0002);

    bus_write(4'h0, 16'h0008);
    check("clr_done", 64'(done), 64'h0);
    bus_read(4'h0, rd); check("clr_ctrl", 64'(rd), 64'h0000);

    // Snapshot coherence
    sum_in = 64'h1111_2222_3333_4444;
    sum_square_in = 64'hAAAA_BBBB_CCCC_DDDD;
    bus_read(4'h8, rd); check("sum_w0", 64'(rd), 64'h4444);
    sum_in = 64'h0;
    sum_square_in = 64'h0;
    bus_read(4'h9, rd); check("sum_w1", 64'(rd), 64'h3333);
    bus_read(4'hA, rd); check("sum_w2", 64'(rd), 64'h2222);
    bus_read(4'hB, rd); check("sum_w3", 64'(rd), 64'h1111);
    bus_read(4'hC, rd); check("sq_w0", 64'(rd), 64'hDDDD);
    bus_read(4'hF, rd); check("sq_w3", 64'(rd), 64'hAAAA);

    // Long run, writes while busy, then abort
    bus_write(4'h4, 16'd100);
    s0 = status_total;
    bus_write(4'h0, 16'h0001);
    check("run100_busy", 64'(busy), 64'h1);
    bus_write(4'h1, 16'h0055);
    check("busy_kert_hold", 64'(KerT), 64'h8001);
    bus_write(4'h4, 16'd7);
    bus_write(4'h0, 16'h0002);
    check("abort_status", 64'(Status), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    check("abort_early", 64'((status_total - s0) < 100), 64'h1);
    bus_read(4'h4, rd); check("busy_runlen_hold", 64'(rd), 64'd100);

    // START together with ABORT does nothing
    bus_write(4'h0, 16'h0003);
    check("start_abort_busy", 64'(busy), 64'h0);

    // Zero-length START is ignored
    bus_write(4'h4, 16'd0);
    bus_write(4'h0, 16'h0001);
    check("zero_len_busy", 64'(busy), 64'h0);
    check("zero_len_status", 64'(Status), 64'h0);

    // Mode bit
    bus_write(4'h0, 16'h0004);
    check("mode_port", 64'(Mode), 64'h1);
    bus_read(4'h0, rd); check("mode_ctrl", 64'(rd), 64'h0004);

    // Asynchronous reset in the middle of a run
    bus_read(4'h1, rd); check("pre_rst_rdata", 64'(rd), 64'h8001);
    bus_write(4'h4, 16'd100);
    bus_write(4'h0, 16'h0005);
    check("pre_rst_status", 64'(Status), 64'h1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("arst_status", 64'(Status), 64'h0);
    check("arst_busy",   64'(busy), 64'h0);
    check("arst_done",   64'(done), 64'h0);
    check("arst_kert",   64'(KerT), 64'h0);
    check("arst_rdata",  64'(bus_rdata), 64'h0);
    check("arst_mode",   64'(Mode), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
